// File: rtl/adv7393_line_unpacker.sv
// -----------------------------------------------------------------------------
// adv7393_line_unpacker
//
// Read side of the ADV7393 line buffer. Pops packed symbols, each holding
// PIXELS_PER_SYMBOL stored pixels of {Y, CbCr}, and expands them into a byte
// stream for the encoder pixel port, CbCr first then Y for every pixel.
// Pixels past the stored line length, or in a group whose symbol was not
// available when it was needed, are replaced by a blank pixel.
//
// Ports
//   clk, rst          : single clock (one tick per output byte), sync reset
//   line_start        : one-cycle pulse from the timing generator per line
//   active_len        : pixels emitted per line, sampled on an accepted start
//   line_len          : pixels stored per line, sampled with active_len
//   s_data/s_valid    : symbol stream from the line buffer FIFO
//   s_ready           : pop strobe toward the FIFO (combinational)
//   out_data          : {byte, zero padding}, registered
//   out_valid/out_last: active-line byte qualifier / final byte of the line
//   underflow         : pulse per group blanked for lack of a symbol
//   overrun           : pulse per ignored start or abandoned symbol debt
//   busy              : FSM is not idle
// -----------------------------------------------------------------------------
module adv7393_line_unpacker #(
  parameter int         PIXELS_PER_SYMBOL = 4,
  parameter int         DATA_W            = 64,
  parameter int         OUT_DWIDTH        = 10,
  parameter int         LEN_W             = 12,
  parameter logic [7:0] BLANK_Y           = 8'h10,
  parameter logic [7:0] BLANK_C           = 8'h80
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  line_start,
  input  logic [LEN_W-1:0]      active_len,
  input  logic [LEN_W-1:0]      line_len,
  input  logic [DATA_W-1:0]     s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [OUT_DWIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_last,
  output logic                  underflow,
  output logic                  overrun,
  output logic                  busy
);

  localparam int IDX_W = (PIXELS_PER_SYMBOL > 1) ? $clog2(PIXELS_PER_SYMBOL) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PIXELS_PER_SYMBOL - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [LEN_W:0]   ROUND_UP = (LEN_W+1)'(PIXELS_PER_SYMBOL - 1);
  localparam logic [LEN_W:0]   DIVISOR  = (LEN_W+1)'(PIXELS_PER_SYMBOL);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN} state_e;

  state_e                  state_q, state_d;
  logic [LEN_W-1:0]        active_len_q, active_len_d;
  logic [LEN_W-1:0]        line_len_q, line_len_d;
  logic [LEN_W-1:0]        debt_q, debt_d;
  logic [LEN_W-1:0]        k_q, k_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    phase_q, phase_d;
  logic [DATA_W-1:0]       sym_q, sym_d;
  logic                    blank_q, blank_d;
  logic [OUT_DWIDTH-1:0]   out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;
  logic                    underflow_q, underflow_d;
  logic                    overrun_q, overrun_d;

  // Symbols owed for the line: ceil(line_len / PIXELS_PER_SYMBOL), one extra
  // bit so line_len near full scale cannot wrap before the divide.
  logic [LEN_W:0]          need;
  logic                    start;
  logic                    fetch;
  logic                    cur_blank;
  logic [DATA_W-1:0]       cur_sym;
  logic [15:0]             pix;
  logic [7:0]              out_byte;

  assign need = ({1'b0, line_len} + ROUND_UP) / DIVISOR;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    active_len_d = active_len_q;
    line_len_d   = line_len_q;
    debt_d       = debt_q;
    k_d          = k_q;
    idx_d        = idx_q;
    phase_d      = phase_q;
    sym_d        = sym_q;
    blank_d      = blank_q;
    out_data_d   = '0;
    out_valid_d  = 1'b0;
    out_last_d   = 1'b0;
    underflow_d  = 1'b0;
    overrun_d    = 1'b0;
    s_ready      = 1'b0;
    start        = 1'b0;
    fetch        = 1'b0;
    cur_blank    = blank_q;
    cur_sym      = sym_q;
    pix          = {BLANK_Y, BLANK_C};
    out_byte     = 8'h00;

    unique case (state_q)
      S_IDLE: begin
        start = line_start;
      end

      S_ACTIVE: begin
        overrun_d = line_start;
        // A group is fetched once, on phase 0 of its first pixel, and only
        // while that pixel is still inside the stored part of the line.
        fetch = !phase_q && (idx_q == '0) && (k_q < line_len_q);
        if (fetch) begin
          s_ready = 1'b1;
          if (s_valid) begin
            // The byte leaving this cycle comes straight from the new symbol.
            sym_d     = s_data;
            cur_sym   = s_data;
            blank_d   = 1'b0;
            cur_blank = 1'b0;
            debt_d    = debt_q - LEN_ONE;
          end else begin
            blank_d     = 1'b1;
            cur_blank   = 1'b1;
            underflow_d = 1'b1;
          end
        end

        if ((k_q < line_len_q) && !cur_blank) begin
          pix = cur_sym[{idx_q, 4'b0000} +: 16];
        end
        out_byte    = phase_q ? pix[15:8] : pix[7:0];
        out_data_d  = {out_byte, {(OUT_DWIDTH-8){1'b0}}};
        out_valid_d = 1'b1;

        if (phase_q) begin
          phase_d = 1'b0;
          if (k_q == active_len_q - LEN_ONE) begin
            out_last_d = 1'b1;
            state_d    = (debt_q != '0) ? S_DRAIN : S_IDLE;
          end else begin
            k_d   = k_q + LEN_ONE;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_ONE;
          end
        end else begin
          phase_d = 1'b1;
        end
      end

      S_DRAIN: begin
        if (line_start) begin
          // No pop here: the symbol at the FIFO head belongs to the new line.
          overrun_d = 1'b1;
          start     = 1'b1;
        end else if (debt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          s_ready = 1'b1;
          if (s_valid) begin
            debt_d = debt_q - LEN_ONE;
            if (debt_q == LEN_ONE) state_d = S_IDLE;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (start) begin
      active_len_d = active_len;
      line_len_d   = line_len;
      debt_d       = LEN_W'(need);
      k_d          = '0;
      idx_d        = '0;
      phase_d      = 1'b0;
      sym_d        = '0;
      blank_d      = 1'b0;
      state_d      = (active_len != '0) ? S_ACTIVE : S_DRAIN;
    end

    if (rst) s_ready = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      active_len_q <= '0;
      line_len_q   <= '0;
      debt_q       <= '0;
      k_q          <= '0;
      idx_q        <= '0;
      phase_q      <= 1'b0;
      blank_q      <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      underflow_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      active_len_q <= active_len_d;
      line_len_q   <= line_len_d;
      debt_q       <= debt_d;
      k_q          <= k_d;
      idx_q        <= idx_d;
      phase_q      <= phase_d;
      blank_q      <= blank_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      underflow_q  <= underflow_d;
      overrun_q    <= overrun_d;
    end
  end

  // NOTE: the symbol register carries no reset; it is cleared on every line
  // start and its contents are only used after a successful fetch.
  always_ff @(posedge clk) begin
    sym_q <= sym_d;
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign underflow = underflow_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_adv7393_line_unpacker.sv
// -----------------------------------------------------------------------------
// tb_adv7393_line_unpacker
//
// Directed bench for adv7393_line_unpacker. Each scenario drives one or two
// line starts from a cycle-indexed schedule, records every output per cycle,
// then compares the recorded trace against hand-derived expectations.
// Cycle c runs from posedge c to posedge c+1; inputs change just after the
// posedge and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_adv7393_line_unpacker;

  logic        clk = 1'b0;
  logic        rst;
  logic        line_start;
  logic [11:0] active_len;
  logic [11:0] line_len;
  logic [63:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [9:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic        underflow;
  logic        overrun;
  logic        busy;

  always #5 clk = ~clk;

  adv7393_line_unpacker dut (
    .clk        (clk),
    .rst        (rst),
    .line_start (line_start),
    .active_len (active_len),
    .line_len   (line_len),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .underflow  (underflow),
    .overrun    (overrun),
    .busy       (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Schedule for one scenario.
  int          ls1, ls2, x_at, rst_at, valid_from;
  logic [11:0] al1, ll1, al2, ll2;
  logic [63:0] symq[$];

  // Per-cycle trace.
  logic [9:0] tr_data  [0:255];
  logic       tr_valid [0:255];
  logic       tr_last  [0:255];
  logic       tr_ready [0:255];
  logic       tr_pop   [0:255];
  logic       tr_uf    [0:255];
  logic       tr_ov    [0:255];
  logic       tr_busy  [0:255];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Symbol whose pixel j is {Y = yb + j, CbCr = cb + j}.
  function automatic logic [63:0] mk(input logic [7:0] yb, input logic [7:0] cb);
    logic [63:0] s;
    s = '0;
    for (int j = 0; j < 4; j++) s[16*j +: 16] = {yb + 8'(j), cb + 8'(j)};
    return s;
  endfunction

  function automatic int count(input logic a [0:255], input int n);
    int c;
    c = 0;
    for (int i = 0; i < n; i++) if (a[i]) c++;
    return c;
  endfunction

  task automatic clear_sched();
    ls1 = -1; ls2 = -1; x_at = -1; rst_at = -1; valid_from = 0;
    symq.delete();
  endtask

  // Must be entered just after a posedge.
  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      line_start = (c == ls1) || (c == ls2) || (c == x_at);
      rst        = (c == rst_at);
      active_len = (ls2 >= 0 && c >= ls2) ? al2 : al1;
      line_len   = (ls2 >= 0 && c >= ls2) ? ll2 : ll1;
      s_valid    = (c >= valid_from) && (symq.size() != 0);
      s_data     = (symq.size() != 0) ? symq[0] : 64'h0;
      @(negedge clk);
      tr_data[c]  = out_data;
      tr_valid[c] = out_valid;
      tr_last[c]  = out_last;
      tr_ready[c] = s_ready;
      tr_pop[c]   = s_ready && s_valid;
      tr_uf[c]    = underflow;
      tr_ov[c]    = overrun;
      tr_busy[c]  = busy;
      @(posedge clk);
      #1;
      if (tr_pop[c]) void'(symq.pop_front());
    end
    line_start = 1'b0;
    rst        = 1'b0;
    s_valid    = 1'b0;
  endtask

  // Checks both bytes of pixel k of a line started at cycle t0.
  task automatic check_pix(input string tag, input int t0, input int k,
                           input logic [7:0] c_exp, input logic [7:0] y_exp);
    check($sformatf("%s_c%0d", tag, k), 32'(tr_data[t0+2+2*k]), 32'({c_exp, 2'b00}));
    check($sformatf("%s_y%0d", tag, k), 32'(tr_data[t0+3+2*k]), 32'({y_exp, 2'b00}));
  endtask

  localparam int T = 2;

  initial begin
    rst = 1'b1; line_start = 1'b0; active_len = '0; line_len = '0;
    s_data = '0; s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // ---------------- reset state ----------------
    @(negedge clk);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_ready", 32'(s_ready), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_data",  32'(out_data), 0);
    check("rst_flags", 32'({out_last, underflow, overrun}), 0);
    @(posedge clk);
    #1;

    // ---------------- nominal line ----------------
    clear_sched();
    ls1 = T; al1 = 12'd8; ll1 = 12'd8;
    symq.push_back(mk(8'h10, 8'h80));
    symq.push_back(mk(8'h14, 8'h84));
    run(22);
    for (int k = 0; k < 8; k++) check_pix("nom", T, k, 8'h80 + 8'(k), 8'h10 + 8'(k));
    check("nom_vcnt",    count(tr_valid, 22), 16);
    check("nom_v_first", 32'(tr_valid[T+2]), 1);
    check("nom_v_end",   32'(tr_valid[T+18]), 0);
    check("nom_last",    32'(tr_last[T+17]), 1);
    check("nom_lcnt",    count(tr_last, 22), 1);
    check("nom_rdy1",    32'(tr_ready[T+1]), 1);
    check("nom_rdy2",    32'(tr_ready[T+9]), 1);
    check("nom_rcnt",    count(tr_ready, 22), 2);
    check("nom_busy16",  32'(tr_busy[T+16]), 1);
    check("nom_busy17",  32'(tr_busy[T+17]), 0);
    check("nom_uf",      count(tr_uf, 22), 0);

    // ---------------- padding ----------------
    clear_sched();
    ls1 = T; al1 = 12'd6; ll1 = 12'd4;
    symq.push_back(mk(8'h20, 8'hA0));
    run(18);
    for (int k = 0; k < 4; k++) check_pix("pad", T, k, 8'hA0 + 8'(k), 8'h20 + 8'(k));
    for (int k = 4; k < 6; k++) check_pix("pad", T, k, 8'h80, 8'h10);
    check("pad_pops", count(tr_pop, 18), 1);
    check("pad_uf",   count(tr_uf, 18), 0);
    check("pad_last", 32'(tr_last[T+13]), 1);
    check("pad_vcnt", count(tr_valid, 18), 12);
    check("pad_busy", 32'(tr_busy[T+13]), 0);

    // ---------------- underflow ----------------
    clear_sched();
    ls1 = T; al1 = 12'd8; ll1 = 12'd8; valid_from = T + 5;
    symq.push_back(mk(8'h30, 8'hB0));
    symq.push_back(mk(8'h40, 8'hC0));
    run(24);
    for (int k = 0; k < 4; k++) check_pix("uf", T, k, 8'h80, 8'h10);
    for (int k = 4; k < 8; k++) check_pix("uf", T, k, 8'hB0 + 8'(k-4), 8'h30 + 8'(k-4));
    check("uf_pulse",  32'(tr_uf[T+2]), 1);
    check("uf_ucnt",   count(tr_uf, 24), 1);
    check("uf_pop9",   32'(tr_pop[T+9]), 1);
    check("uf_pop17",  32'(tr_pop[T+17]), 1);
    check("uf_pops",   count(tr_pop, 24), 2);
    check("uf_busy17", 32'(tr_busy[T+17]), 1);
    check("uf_busy18", 32'(tr_busy[T+18]), 0);
    check("uf_qleft",  symq.size(), 0);

    // ---------------- excess stored ----------------
    clear_sched();
    ls1 = T; al1 = 12'd4; ll1 = 12'd12;
    symq.push_back(mk(8'h50, 8'hD0));
    symq.push_back(mk(8'h60, 8'hE0));
    symq.push_back(mk(8'h70, 8'hF0));
    run(16);
    for (int k = 0; k < 4; k++) check_pix("exc", T, k, 8'hD0 + 8'(k), 8'h50 + 8'(k));
    check("exc_vcnt",   count(tr_valid, 16), 8);
    check("exc_last",   32'(tr_last[T+9]), 1);
    check("exc_pop9",   32'(tr_pop[T+9]), 1);
    check("exc_pop10",  32'(tr_pop[T+10]), 1);
    check("exc_pops",   count(tr_pop, 16), 3);
    check("exc_busy10", 32'(tr_busy[T+10]), 1);
    check("exc_busy11", 32'(tr_busy[T+11]), 0);

    // ---------------- overrun / back-to-back ----------------
    clear_sched();
    ls1 = T; x_at = T + 5; ls2 = T + 9;
    al1 = 12'd4; ll1 = 12'd4; al2 = 12'd4; ll2 = 12'd4;
    symq.push_back(mk(8'h20, 8'h90));
    symq.push_back(mk(8'h28, 8'h98));
    run(24);
    check("ovr_pulse", 32'(tr_ov[T+6]), 1);
    check("ovr_ocnt",  count(tr_ov, 24), 1);
    for (int k = 0; k < 4; k++) check_pix("ovr1", T, k, 8'h90 + 8'(k), 8'h20 + 8'(k));
    for (int k = 0; k < 4; k++) check_pix("ovr2", T + 9, k, 8'h98 + 8'(k), 8'h28 + 8'(k));
    check("ovr_last1", 32'(tr_last[T+9]), 1);
    check("ovr_last2", 32'(tr_last[T+18]), 1);
    check("ovr_pop2",  32'(tr_pop[T+10]), 1);
    check("ovr_pops",  count(tr_pop, 24), 2);
    check("ovr_vcnt",  count(tr_valid, 24), 16);

    // ---------------- reset mid-line ----------------
    clear_sched();
    ls1 = T; rst_at = T + 6; ls2 = T + 10;
    al1 = 12'd768; ll1 = 12'd640; al2 = 12'd4; ll2 = 12'd4;
    symq.push_back(mk(8'h11, 8'h81));
    symq.push_back(mk(8'h31, 8'hA1));
    run(26);
    check("mrst_v6",    32'(tr_valid[T+6]), 1);
    check("mrst_busy6", 32'(tr_busy[T+6]), 1);
    check("mrst_v7",    32'(tr_valid[T+7]), 0);
    check("mrst_busy7", 32'(tr_busy[T+7]), 0);
    check("mrst_data7", 32'(tr_data[T+7]), 0);
    for (int c = T + 7; c < T + 10; c++) check($sformatf("mrst_rdy%0d", c), 32'(tr_ready[c]), 0);
    for (int k = 0; k < 4; k++) check_pix("mrst", T + 10, k, 8'hA1 + 8'(k), 8'h31 + 8'(k));
    check("mrst_last",  32'(tr_last[T+19]), 1);
    check("mrst_pops",  count(tr_pop, 26), 2);
    check("mrst_busy",  32'(tr_busy[25]), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adv7393_line_unpacker.md
# adv7393_line_unpacker

Read side of the ADV7393 line buffer. It pops compressed 64-bit symbols (4 stored pixels × {Y, CbCr}) from the line buffer. It expands them into the 10-bit byte stream driven toward the encoder pixel port, CbCr first then Y per pixel, padding with blank pixels past the stored line and on buffer underflow. It sits between the line buffer FIFO and the active-video mux of the timing generator, which issues `line_start` once per active line.

## Interface
Parameters:
- `PIXELS_PER_SYMBOL`, 4: stored pixels per input symbol.
- `DATA_W`, 64: symbol width; must equal 16×`PIXELS_PER_SYMBOL`.
- `OUT_DWIDTH`, 10: output bus width.
- `LEN_W`, 12: width of the length inputs.
- `BLANK_Y`, 8'h10: Y byte of the blank pixel.
- `BLANK_C`, 8'h80: CbCr byte of the blank pixel.

Ports:
- `clk`, in, 1: the single clock; one tick per output byte.
- `rst`, in, 1: synchronous, active-high reset.
- `line_start`, in, 1: one-cycle pulse starting an active line.
- `active_len`, in, LEN_W: pixels to emit per line (768 for PAL); sampled on accepted `line_start`.
- `line_len`, in, LEN_W: stored pixels per line (640); sampled with `active_len`.
- `s_data`, in, DATA_W: symbol. Pixel i is at bits [16i+15:16i]; Y is [16i+15:16i+8] and CbCr is [16i+7:16i].
- `s_valid`, in, 1: symbol available.
- `s_ready`, out, 1: pop strobe.
- `out_data`, out, OUT_DWIDTH: {byte, 2'b00}.
- `out_valid`, out, 1: `out_data` carries an active-line byte.
- `out_last`, out, 1: last byte of the line.
- `underflow`, out, 1: one-cycle pulse per blanked symbol group.
- `overrun`, out, 1: one-cycle pulse when a `line_start` is ignored or owed symbols are abandoned.
- `busy`, out, 1: state ≠ IDLE.

## Operation
- States: IDLE, ACTIVE, DRAIN.
- **IDLE:**
  - `line_start` latches the lengths and computes `need = ceil(line_len/4)`.
  - `debt` is set to `need`, and the pixel counter k, the phase and the unpacked symbol register are cleared.
  - Transition: to ACTIVE if `active_len` > 0, else to DRAIN.
- **ACTIVE:** pixel k occupies two cycles, phase 0 then phase 1.
  - **Group fetch** (phase 0 with k%4 == 0 and k < `line_len`):
    - `s_ready` = 1.
    - `s_valid` = 1: the symbol is loaded and `debt` is decremented.
    - `s_valid` = 0: the group is marked blank, `debt` is unchanged, and `underflow` pulses on the following cycle.
  - **Pixel source:** pixels k ≥ `line_len`, or in a blanked group, output `BLANK_C`/`BLANK_Y`. Otherwise the byte comes from the unpacked register at index k%4.
  - **Byte order:** CbCr byte in phase 0, Y byte in phase 1.
  - **End of line:** after pixel `active_len`−1 phase 1, go to DRAIN if `debt` > 0, else IDLE.
- **DRAIN:** discards symbols owed to the finished line (underflows, or `line_len` > `active_len`).
  - `s_ready` = 1, and each pop decrements `debt`.
  - Return to IDLE when `debt` reaches 0.
  - `line_start` in DRAIN: pulse `overrun`, abandon `debt`, and start the new line exactly as from IDLE.
- **`line_start` in ACTIVE:** ignored; `overrun` pulses.
- **Arithmetic:** counters are LEN_W bits. `need` is computed as (`line_len`+3)>>2 at LEN_W+1 bits. `line_len` = 0 never fetches and yields an all-blank line.
- **Reset:** `rst` mid-line returns to IDLE the next cycle. All outputs are 0, except `out_data` = 0 and `s_ready` = 0. No pop occurs in the reset cycle.

## Timing
- `line_start` at cycle T, accepted: state is ACTIVE from T+1.
- Pixel k phase 0 is cycle T+1+2k; `s_ready` for its group is asserted combinationally in that cycle.
- `out_data`/`out_valid` are registered: the CbCr of pixel k appears at T+2+2k and its Y at T+3+2k.
- Latency is 2 cycles. `out_valid` is high for exactly 2·`active_len` cycles, from T+2 to T+1+2·`active_len`. `out_last` coincides with the final cycle.
- A new `line_start` may be accepted at T+1+2·`active_len` (the state is IDLE or DRAIN then); output bytes are then back-to-back with no gap.
- `s_ready` is never high for two consecutive cycles in ACTIVE. In DRAIN it may be held high continuously.
- `underflow` pulses at T+2+2k for the blanked group starting at pixel k.

## Test plan
- **Nominal line:** `line_len`=8, `active_len`=8, with two symbols ready (pixel i = {Y=0x10+i, C=0x80+i}).
  - `out_data`>>2 = 80,10,81,11,…,87,17 from T+2.
  - `out_last` at T+17; `s_ready` pulses at T+1 and T+9; `busy` falls at T+17.
- **Padding:** `line_len`=4, `active_len`=6, one symbol.
  - 4 stored pixels, then 2 pixels of 80/10; exactly one pop; no `underflow`.
- **Underflow:** `line_len`=8, `active_len`=8, `s_valid`=0 until T+5.
  - Pixels 0–3 are blank and `underflow` pulses at T+2.
  - The symbol presented at T+9 is popped and shown as pixels 4–7.
  - DRAIN pops one more symbol, then IDLE.
- **Excess stored:** `line_len`=12, `active_len`=4, three symbols.
  - 4 pixels output; DRAIN pops the remaining 2 symbols, then IDLE.
- **Overrun/back-to-back:**
  - `line_start` at T+5 during ACTIVE: `overrun` pulse, and the line continues unchanged.
  - `line_start` at T+1+2·`active_len`: the next line's bytes start with no gap.
- **Reset:** `rst` asserted at T+6 of a 768-pixel line.
  - `out_valid`, `s_ready`, `busy` = 0 from T+7.
  - A subsequent `line_start` produces a correct line.
